fp_packer_seq: RTL and testbench

- Inverse of the operand unpack path: takes an unpacked sign/exponent/fraction triple and produces a packed IEEE-754 double or single word.
- Normalizes iteratively over multiple cycles with a bounded shifter.
- Sits between iterative datapaths (divider, converter) and the packed-operand inputs of the FPU adder path.
- Valid/ready handshake on input and output; one operation in flight.

---
 rtl/fp_packer_seq.sv | 248 ++++++++++++++++++++++++
 tb/tb_fp_packer_seq.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_packer_seq.sv
// Iterative packer: normalizes a sign/exponent/fraction triple over several cycles and emits an IEEE-754 double or single.
// Optional macro FPACK_RNE_EN selects round-to-nearest-even; when it is undefined the result is truncated toward zero.
module fp_packer_seq #(
    parameter int SHIFT_STEP = 8,
    parameter int EXP_W      = 13
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             db,
    input  logic             s_in,
    input  logic [EXP_W-1:0] e_in,
    input  logic [52:0]      f_in,
    input  logic             inf_in,
    input  logic             nan_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      fp_out,
    output logic             inexact,
    output logic             ovf,
    output logic             unf,
    output logic [1:0]       dbg_state_o
);
    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // valid never depends on ready, and the payload stays stable while valid is high and ready is low.
    typedef enum logic [1:0] {IDLE = 2'd0, NORM = 2'd1, PACK = 2'd2, DONE = 2'd3} state_t;

    localparam logic signed [EXP_W-1:0] EMIN_DP = EXP_W'(-1022);
    localparam logic signed [EXP_W-1:0] EMIN_SP = EXP_W'(-126);
    localparam logic signed [EXP_W-1:0] EMAX_DP = EXP_W'(1023);
    localparam logic signed [EXP_W-1:0] EMAX_SP = EXP_W'(127);
    localparam logic signed [EXP_W-1:0] BIAS_DP = EXP_W'(1023);
    localparam logic signed [EXP_W-1:0] BIAS_SP = EXP_W'(127);
    localparam logic [6:0]              STEP7   = 7'(SHIFT_STEP);

    state_t                  state_q, state_d;
    logic                    db_q, db_d, s_q, s_d, nan_q, nan_d, inf_q, inf_d, zero_q, zero_d;
    logic signed [EXP_W-1:0] e_q, e_d;
    logic [52:0]             f_q, f_d;
    logic                    g_q, g_d, r_q, r_d, st_q, st_d;
    logic [63:0]             fp_q, fp_d;
    logic                    inexact_q, inexact_d, ovf_q, ovf_d, unf_q, unf_d;

    logic signed [EXP_W-1:0] emin_in, emin_q, emax_q, e_lsh;
    logic signed [EXP_W:0]   diff;
    logic [EXP_W:0]          rdiff;
    logic [5:0]              lz;
    logic [6:0]              diff_c, lamt, ramt;
    logic [107:0]            rsh;
    logic [52:0]             f_lsh;

    logic        rg, rr, rs, rnd_up;
    logic [10:0] bexp_dp;
    logic [7:0]  bexp_sp;
    logic [62:0] mag_dp;
    logic [30:0] mag_sp;
    logic [63:0] inf_word, pk_fp;
    logic        pk_inx, pk_ovf, pk_unf;

    function automatic logic [5:0] lzc53(input logic [52:0] v);
        lzc53 = 6'd53;
        for (int i = 0; i <= 52; i++) begin
            if (v[i]) lzc53 = 6'(52 - i);
        end
    endfunction

    assign emin_in = db ? EMIN_DP : EMIN_SP;
    assign emin_q  = db_q ? EMIN_DP : EMIN_SP;
    assign emax_q  = db_q ? EMAX_DP : EMAX_SP;
    assign diff    = {e_q[EXP_W-1], e_q} - {emin_q[EXP_W-1], emin_q};
    assign rdiff   = -diff;
    assign lz      = lzc53(f_q);
    assign diff_c  = (|diff[EXP_W-1:6]) ? 7'd63 : {1'b0, diff[5:0]};

    // Left step is bounded by the leading-zero count, the shifter width and the room above emin.
    always_comb begin
        lamt = {1'b0, lz};
        if (STEP7 < lamt) lamt = STEP7;
        if (diff_c < lamt) lamt = diff_c;
    end

    // Right shifts saturate at 55: everything then lands in the guard/round/sticky field.
    assign ramt  = ((|rdiff[EXP_W:6]) || (rdiff[5:0] > 6'd55)) ? 7'd55 : {1'b0, rdiff[5:0]};
    assign rsh   = {f_q, 55'd0} >> ramt;
    assign f_lsh = f_q << lamt;
    assign e_lsh = e_q - {{(EXP_W-7){1'b0}}, lamt};

    assign bexp_dp  = f_q[52] ? 11'(e_q + BIAS_DP) : 11'd0;
    assign bexp_sp  = f_q[52] ? 8'(e_q + BIAS_SP) : 8'd0;
    assign inf_word = db_q ? {s_q, 11'h7FF, 52'd0} : {32'd0, s_q, 8'hFF, 23'd0};

    always_comb begin
        if (db_q) begin
            rg = g_q;
            rr = r_q;
            rs = st_q;
        end else begin
            rg = f_q[28];
            rr = f_q[27];
            rs = (|f_q[26:0]) | g_q | r_q | st_q;
        end
        rnd_up = 1'b0;
`ifdef FPACK_RNE_EN
        rnd_up = rg && (rr || rs || (db_q ? f_q[0] : f_q[29]));
`endif
        // Adding into {exponent, fraction} lets a fraction carry bump the exponent naturally.
        mag_dp = {bexp_dp, f_q[51:0]} + {62'd0, rnd_up};
        mag_sp = {bexp_sp, f_q[51:29]} + {30'd0, rnd_up};
        pk_fp  = 64'd0;
        pk_inx = 1'b0;
        pk_ovf = 1'b0;
        pk_unf = 1'b0;
        if (nan_q) begin
            pk_fp = db_q ? 64'h7FF8000000000000 : 64'h000000007FC00000;
        end else if (inf_q) begin
            pk_fp = inf_word;
        end else if (zero_q) begin
            pk_fp = db_q ? {s_q, 63'd0} : {32'd0, s_q, 31'd0};
        end else if (e_q > emax_q) begin
            pk_fp  = inf_word;
            pk_ovf = 1'b1;
            pk_inx = 1'b1;
        end else begin
            pk_inx = rg | rr | rs;
            if (db_q) begin
                pk_fp  = {s_q, mag_dp};
                pk_ovf = &mag_dp[62:52];
                pk_unf = ~(|mag_dp[62:52]) & pk_inx;
            end else begin
                pk_fp  = {32'd0, s_q, mag_sp};
                pk_ovf = &mag_sp[30:23];
                pk_unf = ~(|mag_sp[30:23]) & pk_inx;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        db_d      = db_q;
        s_d       = s_q;
        nan_d     = nan_q;
        inf_d     = inf_q;
        zero_d    = zero_q;
        e_d       = e_q;
        f_d       = f_q;
        g_d       = g_q;
        r_d       = r_q;
        st_d      = st_q;
        fp_d      = fp_q;
        inexact_d = inexact_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    db_d   = db;
                    s_d    = s_in;
                    nan_d  = nan_in;
                    inf_d  = inf_in;
                    zero_d = (f_in == 53'd0);
                    e_d    = e_in;
                    f_d    = f_in;
                    g_d    = 1'b0;
                    r_d    = 1'b0;
                    st_d   = 1'b0;
                    if (nan_in || inf_in || (f_in == 53'd0)) begin
                        state_d = PACK;
                    end else if (($signed(e_in) < emin_in) ||
                                 (!f_in[52] && ($signed(e_in) > emin_in))) begin
                        state_d = NORM;
                    end else begin
                        state_d = PACK;
                    end
                end
            end
            NORM: begin
                if (diff[EXP_W]) begin
                    f_d     = rsh[107:55];
                    g_d     = rsh[54];
                    r_d     = rsh[53];
                    st_d    = |rsh[52:0];
                    e_d     = emin_q;
                    state_d = PACK;
                end else begin
                    f_d = f_lsh;
                    e_d = e_lsh;
                    if (f_lsh[52] || (e_lsh == emin_q)) state_d = PACK;
                end
            end
            PACK: begin
                fp_d      = pk_fp;
                inexact_d = pk_inx;
                ovf_d     = pk_ovf;
                unf_d     = pk_unf;
                state_d   = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            db_q      <= 1'b0;
            s_q       <= 1'b0;
            nan_q     <= 1'b0;
            inf_q     <= 1'b0;
            zero_q    <= 1'b0;
            e_q       <= '0;
            f_q       <= '0;
            g_q       <= 1'b0;
            r_q       <= 1'b0;
            st_q      <= 1'b0;
            fp_q      <= '0;
            inexact_q <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            db_q      <= db_d;
            s_q       <= s_d;
            nan_q     <= nan_d;
            inf_q     <= inf_d;
            zero_q    <= zero_d;
            e_q       <= e_d;
            f_q       <= f_d;
            g_q       <= g_d;
            r_q       <= r_d;
            st_q      <= st_d;
            fp_q      <= fp_d;
            inexact_q <= inexact_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign fp_out      = fp_q;
    assign inexact     = inexact_q;
    assign ovf         = ovf_q;
    assign unf         = unf_q;
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_fp_packer_seq.sv
// Bench for fp_packer_seq: directed cases plus randomized operands checked against a value-level packing model.
module tb_fp_packer_seq;
    localparam int STEP = 8;
    localparam int EW   = 13;

    logic          clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, db = 1'b0, s_in = 1'b0;
    logic          inf_in = 1'b0, nan_in = 1'b0, out_ready = 1'b0;
    logic [EW-1:0] e_in = '0;
    logic [52:0]   f_in = '0;
    logic          in_ready, out_valid, inexact, ovf, unf;
    logic [63:0]   fp_out;
    logic [1:0]    dbg_state;

    logic [66:0] exp_q[$];
    int          exp_cyc_q[$];
    int          n_checks = 0, n_fail = 0, cyc = 0, hold_cnt = 0;
    bit          rand_ready = 1'b0, seen = 1'b0;

    fp_packer_seq #(.SHIFT_STEP(STEP), .EXP_W(EW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .db(db), .s_in(s_in),
        .e_in(e_in), .f_in(f_in), .inf_in(inf_in), .nan_in(nan_in), .out_valid(out_valid),
        .out_ready(out_ready), .fp_out(fp_out), .inexact(inexact), .ovf(ovf), .unf(unf),
        .dbg_state_o(dbg_state)
    );

    // ---- clock / reset ----
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    initial begin
        #5000000;
        $display("FAIL watchdog expired cycle=%0d required=finish", cyc);
        $fatal(1, "watchdog");
    end

    // ---- reference model: value-level packing from the leading-one position ----
    function automatic logic [63:0] inf_val(input logic d, input logic s);
        return d ? {s, 11'h7FF, 52'd0} : {32'd0, s, 8'hFF, 23'd0};
    endfunction

    function automatic logic [66:0] model(input logic d, input logic s, input int e,
                                          input logic [52:0] f, input logic inf, input logic nan);
        int          emin, emax, bias, fb, p, ee, t;
        logic [63:0] fp, mant, field, f64;
        logic        inx, ov, un;
        fp = 64'd0; inx = 1'b0; ov = 1'b0; un = 1'b0;
        emin = d ? -1022 : -126;
        emax = d ? 1023 : 127;
        bias = d ? 1023 : 127;
        fb   = d ? 52 : 23;
        f64  = {11'd0, f};
        if (nan) fp = d ? 64'h7FF8000000000000 : 64'h000000007FC00000;
        else if (inf) fp = inf_val(d, s);
        else if (f == 53'd0) fp = d ? {s, 63'd0} : {32'd0, s, 31'd0};
        else begin
            p = 0;
            for (int i = 0; i < 53; i++) if (f[i]) p = i;
            ee = e - (52 - p);
            if (ee > emax) begin
                fp = inf_val(d, s); ov = 1'b1; inx = 1'b1;
            end else if (ee >= emin) begin
                mant = f64 << (52 - p);
                if (d) fp = {s, 11'(ee + bias), mant[51:0]};
                else begin
                    fp  = {32'd0, s, 8'(ee + bias), mant[51:29]};
                    inx = |mant[28:0];
                end
            end else begin
                // denormal: fraction field counts units of 2^(emin-fb)
                t = (e - emin) - (52 - fb);
                if (t >= 0) field = f64 << t;
                else if (-t >= 64) begin field = 64'd0; inx = 1'b1; end
                else begin
                    field = f64 >> (-t);
                    inx   = ((field << (-t)) != f64);
                end
                fp = d ? {s, 11'd0, field[51:0]} : {32'd0, s, 8'd0, field[22:0]};
                un = inx;
            end
        end
        return {fp, inx, ov, un};
    endfunction

    function automatic int norm_cycles(input logic d, input int e, input logic [52:0] f,
                                       input logic inf, input logic nan);
        int emin, p, need;
        emin = d ? -1022 : -126;
        if (nan || inf || f == 53'd0) return 0;
        if (e < emin) return 1;
        p = 0;
        for (int i = 0; i < 53; i++) if (f[i]) p = i;
        need = 52 - p;
        if (e - emin < need) need = e - emin;
        return (need + STEP - 1) / STEP;
    endfunction

    task automatic chk(input string name, input logic [66:0] got, input logic [66:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%h required=%h", name, got, want);
        end
    endtask

    // ---- driver ----
    task automatic send(input logic d, input logic s, input int e, input logic [52:0] f,
                        input logic inf, input logic nan);
        int budget = 0;
        @(negedge clk);
        db = d; s_in = s; e_in = EW'(e); f_in = f; inf_in = inf; nan_in = nan; in_valid = 1'b1;
        while (!in_ready && budget < 300) begin
            @(negedge clk);
            budget++;
        end
        n_checks++;
        if (!in_ready) begin
            n_fail++;
            $display("FAIL accept_timeout in_ready=%b required=1", in_ready);
            in_valid = 1'b0;
            return;
        end
        exp_q.push_back(model(d, s, e, f, inf, nan));
        exp_cyc_q.push_back(cyc + 2 + norm_cycles(d, e, f, inf, nan));
        @(negedge clk);
        in_valid = 1'b0;
        e_in = EW'($urandom); f_in = {$urandom, $urandom}; s_in = ~s; db = ~d;
        inf_in = 1'b0; nan_in = 1'b0;
    endtask

    task automatic drain();
        int b = 0;
        while ((exp_q.size() != 0 || out_valid) && b < 500) begin
            @(negedge clk);
            b++;
        end
        chk("drain_pending", 67'(exp_q.size()), 67'd0);
        exp_q.delete();
        exp_cyc_q.delete();
        @(negedge clk);
    endtask

    // ---- scoreboard: compare every cycle the result is presented ----
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out_valid", {66'd0, out_valid}, 67'd0);
            end else begin
                chk("result", {fp_out, inexact, ovf, unf}, exp_q[0]);
                if (!seen) begin
                    chk("latency_cycle", 67'(cyc), 67'(exp_cyc_q[0]));
                    seen = 1'b1;
                end
                chk("in_ready_while_done", {66'd0, in_ready}, 67'd0);
                if (hold_cnt > 0) begin
                    out_ready = 1'b0;
                    hold_cnt--;
                end else begin
                    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    void'(exp_cyc_q.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    // ---- stimulus ----
    initial begin
        logic [63:0] rnd;
        logic [52:0] f;
        logic        d, s, inf, nan;
        int          e;

        repeat (3) @(negedge clk);
        chk("reset_outputs", {fp_out, inexact, ovf, unf}, 67'd0);
        chk("reset_out_valid", {66'd0, out_valid}, 67'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_in_ready", {66'd0, in_ready}, 67'd1);

        // hand-computed values pin the model
        chk("pin_one", model(1, 0, 0, 53'h10000000000000, 0, 0), {64'h3FF0000000000000, 3'b000});
        chk("pin_one_shifted", model(1, 0, 52, 53'h1, 0, 0), {64'h3FF0000000000000, 3'b000});
        chk("pin_norm_cycles0", 67'(norm_cycles(1, 0, 53'h10000000000000, 0, 0)), 67'd0);
        chk("pin_norm_cycles7", 67'(norm_cycles(1, 52, 53'h1, 0, 0)), 67'd7);
        chk("pin_sp_trunc", model(0, 1, 0, 53'h10000000000001, 0, 0), {64'h00000000BF800000, 3'b100});
        chk("pin_ovf", model(1, 0, 1024, 53'h10000000000000, 0, 0), {64'h7FF0000000000000, 3'b110});
        chk("pin_denorm", model(1, 0, -1023, 53'h10000000000000, 0, 0), {64'h0008000000000000, 3'b000});
        chk("pin_nan", model(1, 1, 5, 53'h3, 0, 1), {64'h7FF8000000000000, 3'b000});

        rand_ready = 1'b0;
        send(1, 0, 0, 53'h10000000000000, 0, 0);
        send(1, 0, 52, 53'h1, 0, 0);
        send(0, 1, 0, 53'h10000000000001, 0, 0);
        send(1, 0, 1024, 53'h10000000000000, 0, 0);
        send(1, 0, -1023, 53'h10000000000000, 0, 0);
        send(0, 1, -126, 53'h00000000000001, 0, 0);
        send(1, 1, -4000, 53'h1FFFFFFFFFFFFF, 0, 0);
        send(0, 0, 3, 53'h0, 0, 0);
        send(0, 1, 0, 53'h5, 1, 0);
        drain();

        hold_cnt = 3;
        send(1, 0, 0, 53'h1, 0, 1);
        drain();
        chk("in_ready_after_nan", {66'd0, in_ready}, 67'd1);

        // reset in the middle of NORM discards the operand
        send(1, 0, 52, 53'h1, 0, 0);
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        exp_cyc_q.delete();
        seen = 1'b0;
        #1;
        chk("midreset_out_valid", {66'd0, out_valid}, 67'd0);
        chk("midreset_outputs", {fp_out, inexact, ovf, unf}, 67'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("postreset_in_ready", {66'd0, in_ready}, 67'd1);
        repeat (12) @(negedge clk);
        chk("postreset_no_result", {66'd0, out_valid}, 67'd0);

        rand_ready = 1'b1;
        for (int k = 0; k < 400; k++) begin
            d = 1'($urandom_range(0, 1));
            s = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) < 7) e = d ? int'($urandom_range(0, 2200)) - 1100
                                                : int'($urandom_range(0, 340)) - 170;
            else e = int'($urandom_range(0, 8191)) - 4096;
            rnd = {$urandom, $urandom};
            f = rnd[52:0] >> $urandom_range(0, 53);
            if ($urandom_range(0, 19) == 0) f = 53'd0;
            inf = ($urandom_range(0, 19) == 0);
            nan = ($urandom_range(0, 19) == 0);
            send(d, s, e, f, inf, nan);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
